// File: rtl/counter5x3_popcount_seq_pkg.sv
// Shared types for the slice-serial popcount block.
// State encoding and default word width.
package counter5x3_popcount_seq_pkg;

  localparam int W_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/counter5x3_popcount_seq_cmp5x3.sv
// 5:3 counter: two full adders plus a carry merge.
// Output is the number of set inputs, 0..5.
module cmp5x3 (
  input  logic [4:0] bits,
  output logic [2:0] cnt
);

  logic s1, c1, s2, c2;

  always_comb begin
    s1 = bits[0] ^ bits[1] ^ bits[2];
    c1 = (bits[0] & bits[1])
       | (bits[0] & bits[2])
       | (bits[1] & bits[2]);
    s2 = s1 ^ bits[3] ^ bits[4];
    c2 = (s1 & bits[3])
       | (s1 & bits[4])
       | (bits[3] & bits[4]);
    // both carries weigh 2; their sum spans 0..4
    cnt = {c1 & c2, c1 ^ c2, s2};
  end

endmodule

// File: rtl/counter5x3_popcount_seq.sv
// Serial popcount, one 5-bit slice per cycle through a shared 5:3 counter.
// POPSEQ_EARLY_EXIT_EN: finish as soon as the remaining slices are all zero.
module counter5x3_popcount_seq
  import counter5x3_popcount_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(W+1)-1:0] out_count,
  output logic                   busy
);

  localparam int NS = W / 5;
  localparam int CW = $clog2(W + 1);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_e state, state_n;

  logic [W-1:0]  sreg;
  logic [CW-1:0] acc;
  logic [CW-1:0] sum;
  logic [IW-1:0] idx;
  logic [2:0]    cnt;
  logic          last;
  logic          exit_now;
  logic          load;
  logic          step;
  logic          finish;

  cmp5x3 u_cmp (
    .bits (sreg[4:0]),
    .cnt  (cnt)
  );

  assign sum  = acc + CW'(cnt);
  assign last = (idx == LAST);

`ifdef POPSEQ_EARLY_EXIT_EN
  assign exit_now = last || ((sreg >> 5) == '0);
`else
  assign exit_now = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (exit_now) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      if (load) begin
        sreg <= in_data;
        acc  <= '0;
        idx  <= '0;
      end else if (step) begin
        sreg <= sreg >> 5;
        acc  <= sum;
        // hold on the final slice so the index never wraps
        if (!last) begin
          idx <= idx + IW'(1);
        end
      end
      if (finish) begin
        out_count <= sum;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_counter5x3_popcount_seq.sv
// Directed and random checks of the serial popcount block at W=40.
// Honors POPSEQ_EARLY_EXIT_EN for expected latency.
module tb_counter5x3_popcount_seq;

  localparam int W  = 40;
  localparam int NS = W / 5;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;
  logic          busy;

  int total  = 0;
  int passed = 0;

  counter5x3_popcount_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int ref_pop(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] d);
`ifdef POPSEQ_EARLY_EXIT_EN
    int hi = 0;
    for (int s = 0; s < NS; s++)
      if (d[5*s +: 5] != 5'd0) hi = s;
    return hi + 1;
`else
    return NS;
`endif
  endfunction

  // accept a word, wait for the result, then check latency and count
  task automatic run_word(input logic [W-1:0] d,
                          input int hold,
                          input bit noisy,
                          input bit verbose);
    int lat;
    int c0;
    @(negedge clk);
    if (verbose) check("ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (verbose) check("busy_run", {busy, in_ready}, 2'b10);
      if (noisy) begin
        in_valid = $urandom_range(0, 1);
        in_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, ref_lat(d));
    check("count", out_count, ref_pop(d));
    c0 = int'(out_count);
    for (int k = 0; k < hold; k++) begin
      if (noisy) begin
        in_valid = $urandom_range(0, 1);
        in_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      if (verbose) begin
        check("hold_count", out_count, c0);
        check("hold_state", {out_valid, in_ready}, 2'b10);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [W-1:0] d;
    bit seen;

    #12;
    check("reset_ctl", {in_ready, out_valid, busy}, 3'b100);
    check("reset_cnt", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", {in_ready, out_valid, busy}, 3'b100);

    run_word({W{1'b1}}, 0, 1'b0, 1'b1);
    run_word('0, 0, 1'b0, 1'b0);
    d = 40'h00_0000_001F;
    run_word(d, 0, 1'b0, 1'b0);
    d = 40'h80_0000_0000;
    run_word(d, 2, 1'b0, 1'b0);
    d = 40'hA5_5A_F0_0F_C3;
    run_word(d, 20, 1'b1, 1'b1);

    // reset at RUN cycle 4 abandons the word
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {W{1'b1}};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", {in_ready, out_valid, busy}, 3'b100);
    check("async_rst_cnt", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_output_after_rst", seen, 0);
    check("ready_after_rst", in_ready, 1);
    d = 40'h80_0000_0001;
    run_word(d, 1, 1'b0, 1'b0);

    // random traffic, random back-pressure, sometimes short words
    for (int t = 0; t < 1000; t++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        d = d >> (5 * $urandom_range(1, NS));
      run_word(d, $urandom_range(0, 3), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
